// File: rtl/lut_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive LUT sweep checker.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int N_IN_DEFAULT = 4;
  localparam int VEC_COUNT    = 2**N_IN_DEFAULT;

  // Counts reach 2^n_in inclusive, so one extra bit is enough.
  function automatic int cnt_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/lut_sweep_checker_if.sv
// Control, DUT-facing and result signals of the sweep checker.
interface lut_sweep_checker_if #(parameter int N_IN = 4);
  import lut_sweep_pkg::*;

  localparam int VEC_N = 2**N_IN;
  localparam int CW    = cnt_width(N_IN);

  logic             start;
  logic             abort;
  logic             hold;
  logic             mode_cont;
  logic [VEC_N-1:0] exp_tt;
  logic             dut_y;
  logic [N_IN-1:0]  vec_out;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    ones_cnt;
  logic [CW-1:0]    err_cnt;
  logic [N_IN-1:0]  first_err_idx;
  logic             err_flag;
  logic [VEC_N-1:0] resp_map;

  modport master (
    input  start, abort, hold, mode_cont, exp_tt, dut_y,
    output vec_out, vec_valid, busy, done, ones_cnt, err_cnt,
           first_err_idx, err_flag, resp_map
  );

  modport slave (
    output start, abort, hold, mode_cont, exp_tt, dut_y,
    input  vec_out, vec_valid, busy, done, ones_cnt, err_cnt,
           first_err_idx, err_flag, resp_map
  );

endinterface

// File: rtl/lut_sweep_checker_dwell_counter.sv
// Modulo-HOLD_CYCLES dwell counter; sample_tick marks the last dwell cycle.
module sweep_dwell_counter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic sample_tick
);

  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [DW-1:0] dwell;

  assign sample_tick = !hold && (dwell == DW'(HOLD_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dwell <= '0;
    end else if (!hold) begin
      dwell <= sample_tick ? '0 : dwell + 1'b1;
    end
  end

endmodule

// File: rtl/lut_sweep_checker.sv
// Drives every input vector to an external combinational DUT, samples its
// output and compares it against a latched expected truth table.
module lut_sweep_checker
  import lut_sweep_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  lut_sweep_checker_if.master bus
);

  localparam int VEC_N = 2**N_IN;
  localparam int CW    = cnt_width(N_IN);

  state_e state, state_nxt;

  logic             sample_tick, dwell_clear;
  logic             busy, vec_valid, last_vec, miss;
  logic             mode_q, done_pulse;
  logic [N_IN-1:0]  vec, acc_first, first_now, res_first;
  logic [VEC_N-1:0] exp_q, acc_map, map_now, res_map;
  logic [CW-1:0]    acc_ones, acc_err, ones_now, err_now, res_ones, res_err;

  assign dwell_clear = (state != ST_DRIVE);

  sweep_dwell_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .clear       (dwell_clear),
    .hold        (bus.hold),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    vec_valid   = 1'b0;
    last_vec    = (vec == '1);
    miss        = (bus.dut_y != exp_q[vec]);
    map_now     = acc_map;
    map_now[vec] = bus.dut_y;
    ones_now    = acc_ones + CW'(bus.dut_y);
    err_now     = acc_err + CW'(miss);
    first_now   = (miss && acc_err == '0) ? vec : acc_first;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy      = 1'b1;
        vec_valid = 1'b1;
        if (bus.abort)                             state_nxt = ST_IDLE;
        else if (sample_tick && last_vec && !mode_q) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start)      state_nxt = ST_DRIVE;
        else if (bus.abort) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      exp_q      <= '0;
      mode_q     <= 1'b0;
      done_pulse <= 1'b0;
      acc_map    <= '0;
      acc_ones   <= '0;
      acc_err    <= '0;
      acc_first  <= '0;
      res_map    <= '0;
      res_ones   <= '0;
      res_err    <= '0;
      res_first  <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (state == ST_DRIVE) begin
        if (bus.abort) begin
          vec <= '0;
        end else if (sample_tick) begin
          acc_map   <= map_now;
          acc_ones  <= ones_now;
          acc_err   <= err_now;
          acc_first <= first_now;
          if (last_vec) begin
            // Final sample folds straight into the published results.
            res_map   <= map_now;
            res_ones  <= ones_now;
            res_err   <= err_now;
            res_first <= first_now;
            vec       <= '0;
            if (mode_q) begin
              done_pulse <= 1'b1;
              acc_map    <= '0;
              acc_ones   <= '0;
              acc_err    <= '0;
              acc_first  <= '0;
            end
          end else begin
            vec <= vec + 1'b1;
          end
        end
      end else begin
        vec <= '0;
        if (bus.start) begin
          exp_q     <= bus.exp_tt;
          mode_q    <= bus.mode_cont;
          acc_map   <= '0;
          acc_ones  <= '0;
          acc_err   <= '0;
          acc_first <= '0;
        end
      end
    end
  end

  assign bus.vec_out       = vec;
  assign bus.vec_valid     = vec_valid;
  assign bus.busy          = busy;
  assign bus.done          = (state == ST_DONE) || done_pulse;
  assign bus.ones_cnt      = res_ones;
  assign bus.err_cnt       = res_err;
  assign bus.first_err_idx = res_first;
  assign bus.err_flag      = (res_err != '0);
  assign bus.resp_map      = res_map;

endmodule
